// File: rtl/fifo_rd_engine_pkg.sv
// Shared types and constants for the FIFO read-side drain engine.
package fifo_rd_pkg;

  // Skid buffer occupancy counter width (holds 0..2).
  localparam int unsigned occ_width = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_rd_engine_if.sv
// Bundle of FIFO read-side and downstream stream signals for fifo_rd_engine.
//   master : engine side (drives re, stream outputs and status)
//   slave  : FIFO/downstream side (drives fifo_full/done/data and m_ready)
interface fifo_rd_engine_if #(
  parameter int unsigned width     = 16,
  parameter int unsigned adr_width = 3
);

  logic                 fifo_full;
  logic                 fifo_done;
  logic [width-1:0]     fifo_data;
  logic                 re;
  logic [width-1:0]     m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 m_last;
  logic                 busy;
  logic                 err;
  logic [adr_width:0]   word_cnt;

  modport master (
    input  fifo_full, fifo_done, fifo_data, m_ready,
    output re, m_data, m_valid, m_last, busy, err, word_cnt
  );

  modport slave (
    output fifo_full, fifo_done, fifo_data, m_ready,
    input  re, m_data, m_valid, m_last, busy, err, word_cnt
  );

endinterface

// File: rtl/fifo_rd_engine_skid_buf.sv
// Two-entry FIFO register pair that absorbs downstream backpressure.
//   clk, rst : clock, async active-low reset
//   push/din : write a word (caller guarantees it never overflows)
//   pop      : remove the oldest word (ignored when empty)
//   valid    : buffer non-empty; data : oldest word; count : occupancy
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int unsigned width = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [width-1:0]     din,
  output logic                 valid,
  output logic [width-1:0]     data,
  output logic [occ_width-1:0] count
);

  logic [width-1:0]     e0;
  logic [width-1:0]     e1;
  logic [occ_width-1:0] cnt;
  logic                 pop_ok_c;

  assign pop_ok_c = pop && (cnt != '0);

  // e0 is always the oldest entry; a pop shifts e1 down.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= '0;
    end else begin
      case ({push, pop_ok_c})
        2'b10: begin
          if (cnt == '0) e0 <= din;
          else           e1 <= din;
          cnt <= cnt + occ_width'(1);
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - occ_width'(1);
        end
        2'b11: begin
          // Occupancy unchanged; the new word goes behind whatever remains.
          if (cnt == occ_width'(1)) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid = (cnt != '0);
  assign data  = e0;
  assign count = cnt;

endmodule

// File: rtl/fifo_rd_engine.sv
// Read-side drain engine: waits for a full FIFO burst, pulls depth words with
// re strobes and streams them out on a valid/ready interface with m_last.
//   clk, rst : clock, async active-low reset
//   bus      : fifo_rd_engine_if.master (FIFO read port, stream, status)
module fifo_rd_engine
  import fifo_rd_pkg::*;
#(
  parameter int unsigned width     = 16,
  parameter int unsigned depth     = 8,
  parameter int unsigned adr_width = 3
) (
  input  logic             clk,
  input  logic             rst,
  fifo_rd_engine_if.master bus
);

  localparam int unsigned cnt_width = adr_width + 1;
  localparam int unsigned occ_ext   = occ_width + 1;
  localparam logic [cnt_width-1:0] depth_c  = cnt_width'(depth);
  localparam logic [cnt_width-1:0] last_idx = cnt_width'(depth - 1);

  state_t               state;
  state_t               state_nxt;
  logic [cnt_width-1:0] issued;
  logic [cnt_width-1:0] word_cnt;
  logic                 re;
  logic                 arm;
  logic                 err;

  logic                 start_c;
  logic                 pop_c;
  logic                 credit_c;
  logic                 re_nxt_c;
  logic                 abort_c;
  logic [occ_ext-1:0]   occ_c;

  logic                 buf_valid;
  logic [width-1:0]     buf_data;
  logic [occ_width-1:0] buf_count;

  assign start_c = (state == IDLE) && arm && bus.fifo_full;
  assign pop_c   = buf_valid && bus.m_ready;

  // Occupancy the buffer will have before the next read lands; a new read is
  // safe only if at least one slot is guaranteed free at capture time.
  assign occ_c    = occ_ext'(buf_count) + occ_ext'(re) - occ_ext'(pop_c);
  assign credit_c = (occ_c < occ_ext'(2));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start_c) state_nxt = DRAIN;
      DRAIN: if ((issued == depth_c) || bus.fifo_done) state_nxt = FLUSH;
      // Leave on the edge that pops the final buffered word.
      FLUSH: if (!re && ((buf_count == '0) ||
                         ((buf_count == occ_width'(1)) && pop_c)))
               state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read issue and abort decode.
  always_comb begin
    re_nxt_c = 1'b0;
    abort_c  = 1'b0;
    if (state == DRAIN) begin
      re_nxt_c = (issued < depth_c) && !bus.fifo_done && credit_c;
      abort_c  = bus.fifo_done && (issued < depth_c);
    end
  end

  // Read strobe, counters, arm and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      re       <= 1'b0;
      issued   <= '0;
      word_cnt <= '0;
      arm      <= 1'b1;
      err      <= 1'b0;
    end else begin
      re <= re_nxt_c;
      if (start_c) begin
        issued   <= '0;
        word_cnt <= '0;
      end else begin
        if (re_nxt_c) issued   <= issued + cnt_width'(1);
        if (pop_c)    word_cnt <= word_cnt + cnt_width'(1);
      end
      // A held-high fifo_full must drop before another burst may start.
      if (start_c)            arm <= 1'b0;
      else if (!bus.fifo_full) arm <= 1'b1;
      if (abort_c) err <= 1'b1;
    end
  end

  // Each re cycle's fifo_data is captured at the edge that ends it.
  rd_skid_buf #(
    .width (width)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (re),
    .pop   (pop_c),
    .din   (bus.fifo_data),
    .valid (buf_valid),
    .data  (buf_data),
    .count (buf_count)
  );

  assign bus.re       = re;
  assign bus.m_valid  = buf_valid;
  assign bus.m_data   = buf_data;
  // Only a complete burst ever has a word at index depth-1.
  assign bus.m_last   = buf_valid && (word_cnt == last_idx);
  assign bus.busy     = (state != IDLE);
  assign bus.err      = err;
  assign bus.word_cnt = word_cnt;

endmodule

// File: tb/tb_fifo_rd_engine.sv
// Self-checking bench for fifo_rd_engine: a FIFO responder and a stream
// scoreboard driven from one directed sequence with randomized data/ready.
module tb_fifo_rd_engine;

  localparam int width     = 16;
  localparam int depth     = 8;
  localparam int adr_width = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_rd_engine_if #(.width(width), .adr_width(adr_width)) bus ();

  fifo_rd_engine #(
    .width     (width),
    .depth     (depth),
    .adr_width (adr_width)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [width-1:0] src[$];
  logic [width-1:0] exp_q[$];

  int cyc, re_cnt, xfer_cnt, last_cnt, last_xfer;
  int first_re, last_re, first_val, last_val, val_cycles;
  int rdy_mode, abort_at, stall_left;
  bit stall_used, rdy_phase, hold;
  logic [width-1:0] hold_data;
  logic             hold_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic init_burst(input bit rnd, input logic [width-1:0] base);
    src.delete();
    exp_q.delete();
    for (int i = 0; i < depth; i++)
      src.push_back(rnd ? width'($urandom) : base + width'(i));
    cyc = 0; re_cnt = 0; xfer_cnt = 0; last_cnt = 0; last_xfer = 0;
    first_re = -1; last_re = -1; first_val = -1; last_val = -1; val_cycles = 0;
    stall_left = 0; stall_used = 1'b0; rdy_phase = 1'b0; hold = 1'b0;
  endtask

  // One clock: drive ready, act as the FIFO, score transfers.
  task automatic tick();
    logic [width-1:0] w;
    @(negedge clk);
    cyc++;
    case (rdy_mode)
      1: begin rdy_phase = !rdy_phase; bus.m_ready = rdy_phase; end
      2: begin
        if (!stall_used && xfer_cnt == 2) begin stall_left = 4; stall_used = 1'b1; end
        bus.m_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end
      3: bus.m_ready = 1'($urandom_range(0, 1));
      default: bus.m_ready = 1'b1;
    endcase
    if (hold) begin
      check("hold_valid", 32'(bus.m_valid), 32'(1));
      check("hold_data", 32'(bus.m_data), 32'(hold_data));
      check("hold_last", 32'(bus.m_last), 32'(hold_last));
    end
    hold      = bus.m_valid && !bus.m_ready;
    hold_data = bus.m_data;
    hold_last = bus.m_last;
    if (bus.re) begin
      re_cnt++;
      if (first_re < 0) first_re = cyc;
      last_re = cyc;
      w = (src.size() > 0) ? src.pop_front() : '0;
      bus.fifo_data = w;
      exp_q.push_back(w);
      if (abort_at > 0 && re_cnt == abort_at) bus.fifo_done = 1'b1;
    end
    check("outstanding_le2", 32'((re_cnt - xfer_cnt) <= 2), 32'(1));
    if (bus.m_valid) begin
      val_cycles++;
      if (first_val < 0) first_val = cyc;
      last_val = cyc;
    end
    if (bus.m_valid && bus.m_ready) begin
      check("exp_avail", 32'(exp_q.size() > 0), 32'(1));
      w = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check("m_data", 32'(bus.m_data), 32'(w));
      check("m_last", 32'(bus.m_last), 32'(xfer_cnt == depth - 1));
      check("word_cnt", 32'(bus.word_cnt), 32'(xfer_cnt));
      if (bus.m_last) last_cnt++;
      xfer_cnt++;
      last_xfer = cyc;
    end
  endtask

  task automatic run_burst(input int n_exp, input bit exp_last, input bit rnd,
                           input logic [width-1:0] base, input bit keep_full,
                           input string tag);
    bit done;
    int idle_cyc;
    done = 1'b0;
    idle_cyc = 0;
    init_burst(rnd, base);
    bus.fifo_full = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      tick();
      if (cyc == 1) check({tag, "_busy_rise"}, 32'(bus.busy), 32'(1));
      if (re_cnt > 0 && !keep_full) bus.fifo_full = 1'b0;
      if (first_re >= 0 && !bus.busy) begin
        done = 1'b1;
        idle_cyc = cyc;
      end
    end
    check({tag, "_done"}, 32'(done), 32'(1));
    check({tag, "_start_lat"}, 32'(first_re), 32'(2));
    check({tag, "_re_count"}, 32'(re_cnt), 32'(n_exp));
    check({tag, "_xfers"}, 32'(xfer_cnt), 32'(n_exp));
    check({tag, "_last_count"}, 32'(last_cnt), 32'(exp_last));
    check({tag, "_leftover"}, 32'(exp_q.size()), 32'(0));
    check({tag, "_word_cnt"}, 32'(bus.word_cnt), 32'(n_exp));
    check({tag, "_busy_fall"}, 32'(idle_cyc - last_xfer), 32'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_re"}, 32'(bus.re), 32'(0));
    check({tag, "_m_valid"}, 32'(bus.m_valid), 32'(0));
    check({tag, "_m_last"}, 32'(bus.m_last), 32'(0));
    check({tag, "_busy"}, 32'(bus.busy), 32'(0));
    check({tag, "_err"}, 32'(bus.err), 32'(0));
    check({tag, "_m_data"}, 32'(bus.m_data), 32'(0));
    check({tag, "_word_cnt"}, 32'(bus.word_cnt), 32'(0));
  endtask

  initial begin
    bit reached;
    bus.fifo_full = 1'b0;
    bus.fifo_done = 1'b0;
    bus.fifo_data = '0;
    bus.m_ready   = 1'b1;
    rdy_mode = 0;
    abort_at = 0;
    hold     = 1'b0;

    // Reset state
    #1;
    check_reset_outputs("rst0");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Normal burst, m_ready held high
    run_burst(depth, 1'b1, 1'b0, 16'h1000, 1'b0, "norm");
    check("norm_re_span", 32'(last_re - first_re), 32'(depth - 1));
    check("norm_valid_run", 32'(val_cycles), 32'(depth));
    check("norm_valid_span", 32'(last_val - first_val), 32'(depth - 1));
    check("norm_err", 32'(bus.err), 32'(0));

    // Backpressure: 4-cycle stall after word 2
    rdy_mode = 2;
    run_burst(depth, 1'b1, 1'b0, 16'h2000, 1'b0, "bp");
    check("bp_re_stalled", 32'((last_re - first_re) > depth - 1), 32'(1));
    check("bp_err", 32'(bus.err), 32'(0));

    // Abort: fifo_done seen at the edge ending the 5th re
    rdy_mode = 0;
    abort_at = 5;
    run_burst(5, 1'b0, 1'b0, 16'h3000, 1'b0, "abort");
    abort_at = 0;
    bus.fifo_done = 1'b0;
    check("abort_err", 32'(bus.err), 32'(1));

    // Re-arm: fifo_full held high after a complete burst
    run_burst(depth, 1'b1, 1'b0, 16'h4000, 1'b1, "rearm_a");
    check("err_sticky", 32'(bus.err), 32'(1));
    re_cnt = 0;
    repeat (6) tick();
    check("rearm_no_re", 32'(re_cnt), 32'(0));
    check("rearm_idle", 32'(bus.busy), 32'(0));
    bus.fifo_full = 1'b0;
    tick();
    run_burst(depth, 1'b1, 1'b0, 16'h4100, 1'b0, "rearm_b");

    // Reset mid-burst after 3 transfers
    init_burst(1'b0, 16'h5000);
    reached = 1'b0;
    bus.fifo_full = 1'b1;
    for (int n = 0; n < 100 && !reached; n++) begin
      tick();
      if (re_cnt > 0) bus.fifo_full = 1'b0;
      if (xfer_cnt == 3) reached = 1'b1;
    end
    check("midrst_reached", 32'(reached), 32'(1));
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    bus.fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_burst(depth, 1'b1, 1'b0, 16'h5100, 1'b0, "post_rst");
    check("post_rst_err", 32'(bus.err), 32'(0));

    // Alternating m_ready with random data
    rdy_mode = 1;
    run_burst(depth, 1'b1, 1'b1, '0, 1'b0, "alt_a");
    run_burst(depth, 1'b1, 1'b1, '0, 1'b0, "alt_b");

    // Random m_ready with random data
    rdy_mode = 3;
    run_burst(depth, 1'b1, 1'b1, '0, 1'b0, "rnd_rdy");
    check("final_err", 32'(bus.err), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
